// File: rtl/dmem_sized_hs.sv
// Byte-addressed little-endian data memory with request/response handshake,
// configurable read latency, sized/sign-extended loads and error reporting.
module dmem_sized_hs #(
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter int unsigned READ_LAT    = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        rvalid_o,
   input  logic        rready_i,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned AW = $clog2(DEPTH_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        rvalid_q, rvalid_d;

   logic [7:0]  mem_q [DEPTH_BYTES];

   logic          accept_s;
   logic [2:0]    nbytes_s;
   logic          size_bad_s;
   logic          misalign_s;
   logic          range_bad_s;
   logic          err_s;
   logic [32:0]   last_s;
   logic [AW-1:0] idx0_s, idx1_s, idx2_s, idx3_s;
   logic [31:0]   raw_s;
   logic [31:0]   ld_val_s;

   assign accept_s = req_i & (state_q == ST_IDLE) & ~rst_i;

   assign idx0_s = addr_i[AW-1:0];
   assign idx1_s = idx0_s + AW'(1);
   assign idx2_s = idx0_s + AW'(2);
   assign idx3_s = idx0_s + AW'(3);
   assign raw_s  = {mem_q[idx3_s], mem_q[idx2_s], mem_q[idx1_s], mem_q[idx0_s]};

   // Decode access size and check alignment / range at the request
   always_comb begin
      nbytes_s   = 3'd0;
      size_bad_s = 1'b0;
      misalign_s = 1'b0;
      case (size_i)
         2'b00: nbytes_s = 3'd1;
         2'b01: begin
            nbytes_s   = 3'd2;
            misalign_s = addr_i[0];
         end
         2'b10: begin
            nbytes_s   = 3'd4;
            misalign_s = (addr_i[1:0] != 2'b00);
         end
         default: size_bad_s = 1'b1;
      endcase
      // 33-bit sum so an address near 2^32 cannot wrap back into range
      last_s      = {1'b0, addr_i} + 33'(nbytes_s) - 33'd1;
      range_bad_s = (last_s >= 33'(DEPTH_BYTES));
      err_s       = size_bad_s | misalign_s | range_bad_s;
   end

   // Format load data; errored accesses return zero
   always_comb begin
      ld_val_s = 32'd0;
      if (err_s) begin
         ld_val_s = 32'd0;
      end else begin
         case (size_i)
            2'b00:   ld_val_s = {{24{sign_i & raw_s[7]}}, raw_s[7:0]};
            2'b01:   ld_val_s = {{16{sign_i & raw_s[15]}}, raw_s[15:0]};
            2'b10:   ld_val_s = raw_s;
            default: ld_val_s = 32'd0;
         endcase
      end
   end

   // Next-state and response register logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      rvalid_d = rvalid_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && !(we_i && !err_s)) begin
               rdata_d = we_i ? 32'd0 : ld_val_s;
               err_d   = err_s;
               if (READ_LAT == 32'd1) begin
                  state_d  = ST_RESP;
                  rvalid_d = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 2'(READ_LAT - 32'd1);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 2'd1) begin
               state_d  = ST_RESP;
               rvalid_d = 1'b1;
               cnt_d    = 2'd0;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_RESP: begin
            if (rready_i) begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b0;
               err_d    = 1'b0;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            cnt_d    = 2'd0;
            rvalid_d = 1'b0;
            err_d    = 1'b0;
         end
      endcase
   end

   // Control and response registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 2'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Storage array; deliberately not reset so contents survive rst_i
   always_ff @(posedge clk_i) begin
      if (accept_s && we_i && !err_s) begin
         mem_q[idx0_s] <= wdata_i[7:0];
         if (size_i != 2'b00) begin
            mem_q[idx1_s] <= wdata_i[15:8];
         end
         if (size_i == 2'b10) begin
            mem_q[idx2_s] <= wdata_i[23:16];
            mem_q[idx3_s] <= wdata_i[31:24];
         end
      end
   end

   assign ready_o  = (state_q == ST_IDLE);
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_dmem_sized_hs.sv
// Randomized self-checking bench for dmem_sized_hs against a byte-array
// reference model of the memory and its error rules.
module tb_dmem_sized_hs;

   localparam int DEPTH = 256;
   localparam int LAT   = 3;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        sign_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        ready_o;
   logic        rvalid_o;
   logic        rready_i;
   logic [31:0] rdata_o;
   logic        err_o;

   logic [7:0] ref_mem [DEPTH];
   int checks   = 0;
   int failures = 0;

   dmem_sized_hs #(.DEPTH_BYTES(DEPTH), .READ_LAT(LAT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
      .size_i(size_i), .sign_i(sign_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .ready_o(ready_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
      .rdata_o(rdata_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] size);
      case (size)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
      int n = nbytes(size);
      longint a = longint'(addr);
      if (n == 0) return 1'b1;
      if ((a % n) != 0) return 1'b1;
      if (a + n > DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sign,
                                            input logic [31:0] addr);
      int n = nbytes(size);
      logic [31:0] v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
      if (sign && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
      int n = nbytes(size);
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
   endtask

   // Wait for rvalid (bounded) starting at the first negedge after acceptance
   task automatic wait_resp(input string tag);
      int n = 1;
      while (!rvalid_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk({tag, ":lat"}, 32'(n), 32'(LAT));
   endtask

   // One complete request; called and returning at a negedge with ready_o high
   task automatic transact(input logic we, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold, input string tag);
      bit e = ref_err(size, addr);
      logic [31:0] exp_d = (e || we) ? 32'd0 : ref_load(size, sign, addr);
      chk({tag, ":rdy_in"}, {31'd0, ready_o}, 32'd1);
      req_i = 1'b1; we_i = we; size_i = size; sign_i = sign; addr_i = addr; wdata_i = wdata;
      @(posedge clk_i);
      @(negedge clk_i);
      req_i = 1'b0;
      if (we && !e) begin
         ref_store(size, addr, wdata);
         chk({tag, ":st_rdy"}, {31'd0, ready_o}, 32'd1);
         chk({tag, ":st_rv"}, {31'd0, rvalid_o}, 32'd0);
      end else begin
         wait_resp(tag);
         chk({tag, ":err"}, {31'd0, err_o}, {31'd0, e});
         if (!we) chk({tag, ":data"}, rdata_o, exp_d);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk({tag, ":hold_rv"}, {31'd0, rvalid_o}, 32'd1);
            chk({tag, ":hold_err"}, {31'd0, err_o}, {31'd0, e});
            chk({tag, ":hold_rdy"}, {31'd0, ready_o}, 32'd0);
            if (!we) chk({tag, ":hold_data"}, rdata_o, exp_d);
         end
         rready_i = 1'b1;
         @(negedge clk_i);
         rready_i = 1'b0;
         chk({tag, ":done_rv"}, {31'd0, rvalid_o}, 32'd0);
         chk({tag, ":done_rdy"}, {31'd0, ready_o}, 32'd1);
         chk({tag, ":done_err"}, {31'd0, err_o}, 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [1:0]  s;
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; sign_i = 1'b0;
      addr_i = 32'd0; wdata_i = 32'd0; rready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_ready", {31'd0, ready_o}, 32'd1);
      chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      for (int w = 0; w < DEPTH / 4; w++) transact(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 0, "init");

      transact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, "st_dead");
      for (int i = 0; i < 4; i++) transact(1'b0, 2'b00, 1'b0, 32'h10 + 32'(i), 32'd0, 0, "ld_byte");
      transact(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5, "ld_word_hold");
      transact(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 0, "ld_byte_sx");
      transact(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 0, "ld_half_sx");
      transact(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 0, "ld_half_zx");
      chk("model_dead", ref_load(2'b10, 1'b0, 32'h10), 32'hDEADBEEF);

      transact(1'b1, 2'b10, 1'b0, 32'h22, 32'h0BADF00D, 0, "st_misal");
      transact(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 0, "ld_after_misal");
      transact(1'b0, 2'b10, 1'b0, 32'(DEPTH - 2), 32'd0, 0, "ld_oor");
      transact(1'b0, 2'b00, 1'b0, 32'(DEPTH - 1), 32'd0, 0, "ld_last_byte");
      transact(1'b0, 2'b11, 1'b0, 32'h8, 32'd0, 0, "ld_size11");
      transact(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'd0, 0, "ld_wrap");

      // Store at edge T, load same address accepted at T+1
      req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; sign_i = 1'b0;
      addr_i = 32'h40; wdata_i = 32'h12345678;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("b2b_rdy", {31'd0, ready_o}, 32'd1);
      ref_store(2'b10, 32'h40, 32'h12345678);
      we_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      req_i = 1'b0;
      wait_resp("b2b");
      chk("b2b_data", rdata_o, 32'h12345678);
      rready_i = 1'b1;
      @(negedge clk_i);
      rready_i = 1'b0;

      // Reset asserted while the load is waiting
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
      @(posedge clk_i);
      @(negedge clk_i);
      req_i = 1'b0;
      chk("wait_rv", {31'd0, rvalid_o}, 32'd0);
      #1 rst_i = 1'b1;
      #1;
      chk("rst_wait_rv", {31'd0, rvalid_o}, 32'd0);
      chk("rst_wait_rdy", {31'd0, ready_o}, 32'd1);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      transact(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 0, "ld_retained");

      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 9))
            0:       a = $urandom;
            1:       a = 32'(DEPTH - 4) + 32'($urandom_range(0, 7));
            default: a = 32'($urandom_range(0, DEPTH - 1));
         endcase
         s = 2'($urandom_range(0, 3));
         transact(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom,
                  int'($urandom_range(0, 2)), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
